spi_byte_engine: RTL and testbench
==================================

// Module: spi_byte_engine
// PURPOSE
//  SPI mode-0 byte shifter: the physical-layer stage directly below spi_controller.
//  Each byte is presented on din while en is high. The engine drives cs/sck/mosi,
//  samples miso, and returns the received byte on dout with a one-cycle data_ready
//  pulse. cs stays low across back-to-back bytes for as long as en stays high.
// PARAMETERS
//  CLK_DIV   2  clk cycles per sck half-period (>=1); one bit = 2*CLK_DIV cycles
//  CS_SETUP  1  clk cycles cs is low before the first sck rising edge (>=1)
//  CS_HOLD   1  clk cycles cs stays low after the last byte before release (>=1)
// PORTS
//  clk         in   1  system clock; all logic is on its rising edge
//  rst         in   1  reset, asynchronous, active-low
//  en          in   1  transfer request; level-sensitive, sampled in IDLE and NEXT
//  din         in   8  byte to transmit; sampled in the same cycle as en
//  dout        out  8  last received byte; updated only in the DONE cycle
//  data_ready  out  1  one-cycle pulse when dout holds a new byte
//  cs          out  1  chip select, active-low
//  sck         out  1  serial clock, idle low (CPOL=0)
//  mosi        out  1  serial data out, MSB first
//  miso        in   1  serial data in, MSB first; sampled on the sck rising edge
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE, cs=1, sck=0, mosi=0, dout=0,
//   data_ready=0, all counters 0. Reset takes effect immediately, mid-byte included;
//   cs rises without waiting for a clk edge. No partial byte is reported.
//  All outputs are registered.
//  States:
//   IDLE:  cs=1, sck=0. When en=1: load shift_reg<=din, mosi<=din[7], cs<=0,
//          go to SETUP.
//   SETUP: hold for CS_SETUP cycles, then go to SHIFT with bit_cnt=0 and div_cnt=0.
//   SHIFT: each bit has two halves.
//          First half (sck=0) lasts CLK_DIV cycles.
//          Entering the second half: sck<=1 and miso is captured into the rx shift
//          register LSB.
//          End of the second half: sck<=0. If bit_cnt<7, mosi<=next bit and
//          bit_cnt++. If bit_cnt=7, go to DONE.
//   DONE:  one cycle. data_ready=1, dout=rx byte, sck=0, cs stays 0.
//   NEXT:  one cycle. Sample en and din. This matches spi_controller, which updates
//          spi_en/mosi_data_i on the edge after data_ready.
//          en=1: load din, mosi<=din[7], go straight to SHIFT with no extra CS_SETUP.
//          en=0: go to HOLD.
//   HOLD:  cs stays 0 for CS_HOLD cycles, then cs<=1, go to IDLE.
//          en is ignored while in HOLD.
//  Latency:
//   en=1 in IDLE -> cs low next cycle.
//   First rising sck at 1+CS_SETUP+CLK_DIV cycles.
//   data_ready at 1+CS_SETUP+16*CLK_DIV cycles.
//   Back-to-back bytes: 16*CLK_DIV+2 cycles per byte.
//  Boundary conditions:
//   en dropped mid-byte: the byte completes and is reported; the engine releases
//    via HOLD.
//   din changes mid-byte: ignored; din is sampled only on IDLE->SETUP and
//    NEXT->SHIFT.
//   en=1 in HOLD: ignored; a new transfer starts from IDLE, so cs pulses high for
//    at least one cycle.
//   data_ready never asserts for two consecutive cycles.
//   sck never toggles while cs=1.
//   dout is stable outside DONE.
// STRUCTURE
//  spi_pkg (shared package):
//   typedef enum logic [2:0] {IDLE,SETUP,SHIFT,DONE,NEXT,HOLD} spi_eng_state_t
//   localparam SPI_BYTE_W=8
//  Sub-module spi_sck_divider: counts CLK_DIV, emits half_tick; cleared by the FSM.
//  Top level: FSM, 3-bit bit_cnt, tx and rx shift registers.
// TESTING (miso looped to mosi unless stated; CLK_DIV=2, CS_SETUP=1, CS_HOLD=1)
//  1. Reset, then hold rst=0 -> cs=1, sck=0, mosi=0, dout=0x00, data_ready=0;
//     outputs stay stable for 20 cycles with en toggling.
//  2. en=1, din=0xA5 for one cycle -> cs low 1 cycle later, exactly 8 sck pulses,
//     mosi sequence 1,0,1,0,0,1,0,1; data_ready at cycle 34 with dout=0xA5;
//     cs high at cycle 36.
//  3. Hold en=1 with din=0x3C then 0xC3 (din updated after the first data_ready)
//     -> cs stays low throughout; data_ready pulses exactly 34 cycles apart;
//     dout reads 0x3C then 0xC3.
//  4. miso tied to 1, din=0x00 -> dout=0xFF, mosi stays 0; all miso sampling
//     occurs while sck=1.
//  5. en dropped at cycle 10 of a byte -> the byte completes, data_ready fires once,
//     cs releases after CS_HOLD; no second byte is sent.
//  6. rst asserted at bit 4 -> cs=1 and sck=0 asynchronously; no data_ready; a
//     following en=1, din=0x5A transfer completes with dout=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI byte engine.
// State encoding and byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        NEXT,
        HOLD
    } spi_eng_state_t;

endpackage

// File: rtl/spi_sck_divider.sv
// Half-period timer for sck generation.
// Emits half_tick every CLK_DIV cycles while run is high.
module spi_sck_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic half_tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt;

    assign half_tick = run && (cnt == W'(CLK_DIV - 1));

    // Count one sck half-period, restarting whenever run drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || half_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter below the SPI controller.
// Drives cs/sck/mosi, samples miso, reports each byte.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SPI_BYTE_W-1:0] din,
    output logic [SPI_BYTE_W-1:0] dout,
    output logic                  data_ready,
    output logic                  cs,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int CMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

    spi_eng_state_t        state_q, state_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_q, rx_d;
    logic [SPI_BYTE_W-1:0] dout_d;
    logic [2:0]            bit_q, bit_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  cs_d, sck_d, mosi_d, rdy_d;
    logic                  half_tick;

    spi_sck_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .run      (state_q == SHIFT),
        .half_tick(half_tick)
    );

    // State and output registers; reset releases cs at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            data_ready <= 1'b0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            dout       <= dout_d;
            data_ready <= rdy_d;
            cs         <= cs_d;
            sck        <= sck_d;
            mosi       <= mosi_d;
        end
    end

    // Next-state and next-output decode for the byte sequencer.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        dout_d  = dout;
        rdy_d   = 1'b0;
        cs_d    = cs;
        sck_d   = sck;
        mosi_d  = mosi;
        unique case (state_q)
            IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                if (en) begin
                    tx_d    = din;
                    mosi_d  = din[SPI_BYTE_W-1];
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (half_tick && !sck) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[SPI_BYTE_W-2:0], miso};
                end else if (half_tick) begin
                    sck_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        dout_d  = rx_q;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                        mosi_d = tx_q[SPI_BYTE_W-2];
                    end
                end
            end
            DONE: begin
                state_d = NEXT;
            end
            NEXT: begin
                if (en) begin
                    tx_d    = din;
                    mosi_d  = din[SPI_BYTE_W-1];
                    bit_d   = '0;
                    state_d = SHIFT;
                end else begin
                    // The NEXT cycle already counts toward the cs hold time.
                    cnt_d   = CW'(1);
                    cs_d    = (CS_HOLD <= 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q >= CW'(CS_HOLD)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q >= CW'(CS_HOLD - 1)) begin
                        cs_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Self-checking bench for spi_byte_engine.
// Timing and data expectations come from a cycle-count model.
module tb_spi_byte_engine;

    localparam int DIV   = 2;
    localparam int SETUP = 1;
    localparam int HOLDC = 1;
    localparam int T_RDY = 1 + SETUP + 16 * DIV;
    localparam int T_B2B = 16 * DIV + 2;
    localparam int T_SCK = 1 + SETUP + DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       data_ready;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso;

    int         miso_mode = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] bytes [0:3];

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

    spi_byte_engine #(
        .CLK_DIV (DIV),
        .CS_SETUP(SETUP),
        .CS_HOLD (HOLDC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .dout      (dout),
        .data_ready(data_ready),
        .cs        (cs),
        .sck       (sck),
        .mosi      (mosi),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_rx(input int k);
        if (miso_mode == 0) return bytes[k];
        if (miso_mode == 1) return 8'hFF;
        return 8'h00;
    endfunction

    // Send n bytes from bytes[]; en drops at drop_at (0: after last byte).
    task automatic xfer(input int n, input int drop_at, input string tag);
        int         cyc = 0;
        int         rdy_cnt = 0;
        int         rises = 0;
        int         last_rdy = -1;
        int         cs_low = -1;
        int         cs_high = -1;
        int         first_rise = -1;
        int         sck_bad = 0;
        int         dout_bad = 0;
        int         exp_bit;
        logic       prev_sck = 1'b0;
        logic       prev_rdy = 1'b0;
        logic [7:0] last_dout = dout;
        logic [7:0] cur;
        en  = 1'b1;
        din = bytes[0];
        while (cyc < 40 * n + 40) begin
            tick();
            cyc++;
            if (drop_at > 0 && cyc == drop_at) en = 1'b0;
            if (drop_at > 0 && cyc > 2) din = 8'($urandom);
            if (cs_low < 0 && cs === 1'b0) cs_low = cyc;
            if (sck === 1'b1 && cs === 1'b1) sck_bad++;
            if (sck === 1'b1 && prev_sck === 1'b0) begin
                if (first_rise < 0) first_rise = cyc;
                if (rises < 8 * n) begin
                    cur = bytes[rises / 8];
                    exp_bit = int'(cur[7 - (rises % 8)]);
                    chk({tag, "_mosi"}, 32'(mosi), 32'(exp_bit));
                end
                rises++;
            end
            if (data_ready === 1'b1) begin
                chk({tag, "_rdy_twice"}, 32'(prev_rdy), 32'd0);
                chk({tag, "_rdy_cyc"}, cyc, T_RDY + T_B2B * rdy_cnt);
                chk({tag, "_dout"}, 32'(dout), 32'(exp_rx(rdy_cnt)));
                last_dout = dout;
                last_rdy = cyc;
                rdy_cnt++;
                if (rdy_cnt < n && drop_at == 0) din = bytes[rdy_cnt];
                else en = 1'b0;
            end else if (dout !== last_dout) begin
                dout_bad++;
            end
            if (rdy_cnt > 0 && cs === 1'b1 && cs_high < 0) cs_high = cyc;
            if (cs_high > 0 && cyc > cs_high + 4) break;
            prev_sck = sck;
            prev_rdy = data_ready;
        end
        chk({tag, "_timeout"}, 32'(cs_high > 0), 32'd1);
        chk({tag, "_rdy_cnt"}, rdy_cnt, n);
        chk({tag, "_sck_cnt"}, rises, 8 * n);
        chk({tag, "_cs_low"}, cs_low, 1);
        chk({tag, "_first_sck"}, first_rise, T_SCK);
        chk({tag, "_cs_high"}, cs_high, last_rdy + 2);
        chk({tag, "_sck_cs"}, sck_bad, 0);
        chk({tag, "_dout_stable"}, dout_bad, 0);
    endtask

    initial begin
        int rises;
        int rdy_seen;
        int n;

        // Reset held with en toggling: outputs stay at reset values.
        for (int i = 0; i < 20; i++) begin
            tick();
            en  = 1'($urandom_range(0, 1));
            din = 8'($urandom);
            chk("rst_cs", 32'(cs), 32'd1);
            chk("rst_sck", 32'(sck), 32'd0);
            chk("rst_mosi", 32'(mosi), 32'd0);
            chk("rst_dout", 32'(dout), 32'h00);
            chk("rst_rdy", 32'(data_ready), 32'd0);
        end
        en = 1'b0;
        rst = 1'b1;
        tick();
        tick();

        // Single byte with a one-cycle en pulse.
        bytes[0] = 8'hA5;
        xfer(1, 1, "a5");

        // Back-to-back bytes with en held high.
        bytes[0] = 8'h3C;
        bytes[1] = 8'hC3;
        xfer(2, 0, "b2b");

        // miso tied high, all-zero transmit.
        miso_mode = 1;
        bytes[0] = 8'h00;
        xfer(1, 1, "miso1");
        miso_mode = 0;

        // en dropped partway through a byte.
        bytes[0] = 8'($urandom);
        xfer(1, 10, "drop");

        // Reset asserted at bit 4 of a byte.
        en = 1'b1;
        din = 8'hFF;
        rises = 0;
        for (int c = 0; c < 100 && rises < 5; c++) begin
            tick();
            en = 1'b0;
            if (sck === 1'b1) begin
                rises++;
                while (sck === 1'b1) tick();
            end
        end
        chk("mid_reach_bit4", rises, 5);
        rst = 1'b0;
        #1;
        chk("mid_async_cs", 32'(cs), 32'd1);
        chk("mid_async_sck", 32'(sck), 32'd0);
        chk("mid_async_dout", 32'(dout), 32'h00);
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_ready === 1'b1) rdy_seen++;
        end
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (data_ready === 1'b1) rdy_seen++;
        end
        chk("mid_no_rdy", rdy_seen, 0);
        chk("mid_idle_cs", 32'(cs), 32'd1);
        bytes[0] = 8'h5A;
        xfer(1, 1, "after_rst");

        // Randomized bursts with varying miso source.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
            miso_mode = $urandom_range(0, 2);
            xfer(n, (n == 1) ? 1 : 0, "rand");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
